parking_timer_scheduler: RTL and testbench
==========================================

// Module: parking_timer_scheduler
// PURPOSE
//  Shares the free-running parking timer (timer_count) among NUM_SLOTS parking slots.
//  - Entry: timestamps the arriving car.
//  - Exit: computes the elapsed stay and emits one duration report over a valid/ready handshake.
//  - Simultaneous slot requests are serialised by a round-robin arbiter.
//  - Sits between the gate/sensor logic and the timer; the billing/display path consumes the reports.
// PARAMETERS
//  NUM_SLOTS  4      number of parking slots / requesters (2..16)
//  TIMER_W    10     width of timer_count and of all timestamps/durations
//  MAX_STAY   900    stay-limit threshold in timer ticks (used only with STAY_ALARM_EN)
// PORTS
//  clk           in   1          system clock, rising edge
//  reset         in   1          asynchronous, active-low (0 = reset)
//  timer_count   in   TIMER_W    free-running timer value; wraps at 2^TIMER_W
//  entry_req     in   NUM_SLOTS  level request per slot: car entering
//  exit_req      in   NUM_SLOTS  level request per slot: car leaving
//  entry_ack     out  NUM_SLOTS  one-hot, 1-cycle pulse: entry granted
//  exit_ack      out  NUM_SLOTS  one-hot, 1-cycle pulse: exit granted
//  occupied      out  NUM_SLOTS  slot holds a timestamped car
//  rpt_valid     out  1          duration report pending
//  rpt_ready     in   1          consumer accepts report
//  rpt_slot      out  $clog2(NUM_SLOTS)  slot index of the report
//  rpt_duration  out  TIMER_W    elapsed ticks of the report
//  stay_alarm    out  NUM_SLOTS  slot over MAX_STAY (tied 0 without STAY_ALARM_EN)
// BEHAVIOUR
//  Reset values (reset=0, async): all outputs 0, all stamps 0, FSM=IDLE, rr pointer=0.
//  Reset mid-operation drops any pending report and clears all occupancy.
//  Eligible request, slot i: (entry_req[i] & ~occupied[i]) | (exit_req[i] & occupied[i]).
//   Ineligible requests are ignored and never acked.
//   If both entry_req[i] and exit_req[i] are high, only the one eligible under occupied[i] counts.
//  FSM states: IDLE, REPORT.
//  IDLE:
//   - Each edge, the RR arbiter grants at most one eligible slot.
//   - Search starts at the pointer; after any grant, pointer <= granted index+1 (mod NUM_SLOTS).
//   - Entry grant i: stamp[i] <= timer_count; occupied[i] <= 1; entry_ack[i] pulses 1 cycle; stay IDLE.
//   - Exit grant i: rpt_duration <= (timer_count - stamp[i]) mod 2^TIMER_W; rpt_slot <= i;
//     occupied[i] <= 0; exit_ack[i] pulses 1 cycle; rpt_valid <= 1; go to REPORT.
//  REPORT:
//   - No grants.
//   - rpt_valid, rpt_slot and rpt_duration hold stable until rpt_valid & rpt_ready.
//   - On acceptance: rpt_valid <= 0 and return to IDLE; first new grant occurs on the next edge.
//  Latency:
//   - Request sampled at edge N; ack/occupied/report visible after edge N.
//   - Ack deasserts after edge N+1.
//   - A request still held after its ack becomes ineligible because occupancy flipped.
//  Wrap: durations are modulo 2^TIMER_W; stays >= 2^TIMER_W ticks alias (documented limitation).
//  Throughput: one entry per cycle; one exit per (2 + report stall) cycles.
// CONFIGURATION
//  STAY_ALARM_EN defined:
//   - stay_alarm[i] <= occupied[i] & ((timer_count - stamp[i]) mod 2^TIMER_W >= MAX_STAY), registered.
//   - Cleared on the edge that grants exit i.
//  STAY_ALARM_EN undefined: stay_alarm tied to 0, no comparators built.
// STRUCTURE
//  parking_defs.vh: FSM state encodings (IDLE/REPORT) and default TIMER_W/NUM_SLOTS constants,
//  shared with the timer and gate logic.
//  Sub-module rr_arbiter: request vector + pointer in, one-hot grant + index out; combinational,
//  with the pointer register kept in the parent.
// TESTING
//  1 Reset: hold reset=0 for 2 cycles with requests active -> all outputs 0, no acks.
//  2 Entry slot1 at timer=100; exit at timer=350, rpt_ready=1 -> rpt_slot=1, rpt_duration=250, one rpt_valid cycle.
//  3 Wrap: entry at 1000, exit at 40 -> rpt_duration=64.
//  4 entry_req=4'b1111 same cycle, pointer 0 -> acks on slots 0,1,2,3 in 4 consecutive cycles.
//  5 Exits on slots 0,2 together, rpt_ready=0 for 5 cycles -> slot0 report held stable; slot2 granted only after acceptance.
//  6 STAY_ALARM_EN, MAX_STAY=900: entry at 0 -> stay_alarm rises after timer reaches 900 and clears on exit;
//    reset mid-REPORT -> rpt_valid=0 immediately.

Source files
------------

// File: rtl/parking_timer_scheduler_pkg.sv
// Shared definitions for the parking timer scheduler: FSM state encoding,
// default slot/timer sizing and the round-robin pointer advance helper.
package parking_timer_scheduler_pkg;

  localparam int DEF_NUM_SLOTS = 4;
  localparam int DEF_TIMER_W   = 10;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_REPORT = 1'b1
  } state_e;

  // Next search start after a grant: one past the winner, wrapping at n.
  function automatic int next_index(input int idx, input int n);
    return (idx + 1 == n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/parking_timer_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or after
// i_ptr. The pointer register itself lives in the parent.
module parking_timer_scheduler_rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  logic [IDX_W-1:0] w_j;

  always_comb begin
    // NOTE: every output gets a default before the search so no path leaves a value held, which would infer a latch.
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_j     = '0;
    for (int k = 0; k < N; k++) begin
      w_j = IDX_W'((int'(i_ptr) + k) % N);
      if (!o_valid && i_req[w_j]) begin
        o_valid       = 1'b1;
        o_grant[w_j]  = 1'b1;
        o_idx         = w_j;
      end
    end
  end

endmodule

// File: rtl/parking_timer_scheduler.sv
// Shares one free-running timer among parking slots: stamps entries, reports
// exit durations over valid/ready. Optional per-slot stay alarm: STAY_ALARM_EN.
module parking_timer_scheduler
  import parking_timer_scheduler_pkg::*;
#(
  parameter int NUM_SLOTS = DEF_NUM_SLOTS,
  parameter int TIMER_W   = DEF_TIMER_W
`ifdef STAY_ALARM_EN
  ,
  parameter int MAX_STAY  = 900
`endif
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [TIMER_W-1:0]           timer_count,
  input  logic [NUM_SLOTS-1:0]         entry_req,
  input  logic [NUM_SLOTS-1:0]         exit_req,
  output logic [NUM_SLOTS-1:0]         entry_ack,
  output logic [NUM_SLOTS-1:0]         exit_ack,
  output logic [NUM_SLOTS-1:0]         occupied,
  output logic                         rpt_valid,
  input  logic                         rpt_ready,
  output logic [$clog2(NUM_SLOTS)-1:0] rpt_slot,
  output logic [TIMER_W-1:0]           rpt_duration,
  output logic [NUM_SLOTS-1:0]         stay_alarm
);

  localparam int IDX_W = $clog2(NUM_SLOTS);

  state_e               r_state, w_next_state;
  logic [IDX_W-1:0]     r_ptr;
  logic [NUM_SLOTS-1:0] r_occupied;
  logic [TIMER_W-1:0]   r_stamp [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] r_entry_ack, r_exit_ack;
  logic                 r_rpt_valid;
  logic [IDX_W-1:0]     r_rpt_slot;
  logic [TIMER_W-1:0]   r_rpt_duration;

  logic [NUM_SLOTS-1:0] w_eligible, w_req, w_grant;
  logic [IDX_W-1:0]     w_idx;
  logic                 w_grant_valid, w_is_exit, w_accept;

  // A request only counts if it matches the slot's current occupancy.
  assign w_eligible = (entry_req & ~r_occupied) | (exit_req & r_occupied);
  assign w_req      = (r_state == ST_IDLE) ? w_eligible : '0;
  assign w_is_exit  = r_occupied[w_idx];

  parking_timer_scheduler_rr_arbiter #(.N(NUM_SLOTS), .IDX_W(IDX_W)) u_arb (
    .i_req   (w_req),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_valid (w_grant_valid)
  );

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    case (r_state)
      ST_IDLE:   if (w_grant_valid && w_is_exit) w_next_state = ST_REPORT;
      ST_REPORT: begin
        w_accept = rpt_ready;
        if (rpt_ready) w_next_state = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr          <= '0;
      r_occupied     <= '0;
      r_entry_ack    <= '0;
      r_exit_ack     <= '0;
      r_rpt_valid    <= 1'b0;
      r_rpt_slot     <= '0;
      r_rpt_duration <= '0;
      // NOTE: the stamp array is reset too, so a stale stamp can never leak into a duration or alarm.
      for (int i = 0; i < NUM_SLOTS; i++) r_stamp[i] <= '0;
    end else begin
      r_entry_ack <= '0;
      r_exit_ack  <= '0;
      if (w_accept) r_rpt_valid <= 1'b0;
      if (w_grant_valid) begin
        r_ptr <= IDX_W'(next_index(int'(w_idx), NUM_SLOTS));
        if (w_is_exit) begin
          r_occupied[w_idx] <= 1'b0;
          r_exit_ack        <= w_grant;
          r_rpt_valid       <= 1'b1;
          r_rpt_slot        <= w_idx;
          r_rpt_duration    <= timer_count - r_stamp[w_idx];
        end else begin
          r_occupied[w_idx] <= 1'b1;
          r_entry_ack       <= w_grant;
          r_stamp[w_idx]    <= timer_count;
        end
      end
    end
  end

  assign entry_ack    = r_entry_ack;
  assign exit_ack     = r_exit_ack;
  assign occupied     = r_occupied;
  assign rpt_valid    = r_rpt_valid;
  assign rpt_slot     = r_rpt_slot;
  assign rpt_duration = r_rpt_duration;

`ifdef STAY_ALARM_EN
  logic [NUM_SLOTS-1:0] r_stay_alarm;
  logic [TIMER_W-1:0]   w_elapsed [NUM_SLOTS];

  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) w_elapsed[i] = timer_count - r_stamp[i];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stay_alarm <= '0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (w_grant_valid && w_is_exit && w_grant[i]) r_stay_alarm[i] <= 1'b0;
        else r_stay_alarm[i] <= r_occupied[i] && (w_elapsed[i] >= TIMER_W'(MAX_STAY));
      end
    end
  end

  assign stay_alarm = r_stay_alarm;
`else
  assign stay_alarm = '0;
`endif

endmodule

// File: tb/tb_parking_timer_scheduler.sv
// Self-checking bench for parking_timer_scheduler: directed scenarios plus a
// randomized run against a slot-level reference model.
module tb_parking_timer_scheduler;

  localparam int N       = 4;
  localparam int TW      = 10;
  localparam int MODV    = 1024;
  localparam int MAXSTAY = 900;

  logic          clk = 1'b0;
  logic          reset;
  logic [TW-1:0] timer_count;
  logic [N-1:0]  entry_req, exit_req;
  logic [N-1:0]  entry_ack, exit_ack, occupied, stay_alarm;
  logic          rpt_valid, rpt_ready;
  logic [1:0]    rpt_slot;
  logic [TW-1:0] rpt_duration;

  int total = 0;
  int bad   = 0;

  // Reference model: which slots hold a car, when it arrived, who searches first.
  logic [N-1:0] m_occ;
  int           m_stamp [N];
  int           m_ptr;
  bit           m_busy;
  int           m_rslot, m_rdur;
  logic [N-1:0] m_eack, m_xack, m_alarm;

  parking_timer_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .timer_count  (timer_count),
    .entry_req    (entry_req),
    .exit_req     (exit_req),
    .entry_ack    (entry_ack),
    .exit_ack     (exit_ack),
    .occupied     (occupied),
    .rpt_valid    (rpt_valid),
    .rpt_ready    (rpt_ready),
    .rpt_slot     (rpt_slot),
    .rpt_duration (rpt_duration),
    .stay_alarm   (stay_alarm)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time budget exceeded");
    $fatal(1);
  end

  function automatic int elapsed(input int now, input int then_);
    return (now - then_ + MODV) % MODV;
  endfunction

  function automatic void model_reset();
    m_occ = '0; m_ptr = 0; m_busy = 0; m_rslot = 0; m_rdur = 0;
    m_eack = '0; m_xack = '0; m_alarm = '0;
    for (int i = 0; i < N; i++) m_stamp[i] = 0;
  endfunction

  function automatic void model_step();
    logic [N-1:0] nxt_alarm;
    if (!reset) begin
      model_reset();
      return;
    end
    for (int i = 0; i < N; i++)
      nxt_alarm[i] = m_occ[i] && (elapsed(int'(timer_count), m_stamp[i]) >= MAXSTAY);
    m_eack = '0;
    m_xack = '0;
    if (m_busy) begin
      if (rpt_ready) m_busy = 0;
    end else begin
      for (int k = 0; k < N; k++) begin
        int j = (m_ptr + k) % N;
        bit want_in  = entry_req[j] && !m_occ[j];
        bit want_out = exit_req[j] && m_occ[j];
        if (want_in || want_out) begin
          if (want_in) begin
            m_occ[j] = 1'b1; m_stamp[j] = int'(timer_count); m_eack[j] = 1'b1;
          end else begin
            m_occ[j] = 1'b0; m_xack[j] = 1'b1; m_busy = 1;
            m_rslot = j; m_rdur = elapsed(int'(timer_count), m_stamp[j]);
            nxt_alarm[j] = 1'b0;
          end
          m_ptr = (j + 1) % N;
          break;
        end
      end
    end
`ifdef STAY_ALARM_EN
    m_alarm = nxt_alarm;
`else
    m_alarm = '0;
`endif
  endfunction

  // One active edge: model follows the same inputs, outputs settle by +1.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    entry_req = '0; exit_req = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0; timer_count = 10'd7; entry_req = '1; exit_req = '1; rpt_ready = 1'b1;
    tick(); tick();
    total++; if (entry_ack !== 4'b0) begin bad++; $display("FAIL reset_entry_ack got=%b exp=0000", entry_ack); end
    total++; if (exit_ack !== 4'b0) begin bad++; $display("FAIL reset_exit_ack got=%b exp=0000", exit_ack); end
    total++; if (occupied !== 4'b0) begin bad++; $display("FAIL reset_occupied got=%b exp=0000", occupied); end
    total++; if (rpt_valid !== 1'b0) begin bad++; $display("FAIL reset_rpt_valid got=%b exp=0", rpt_valid); end
    total++; if (rpt_slot !== 2'd0 || rpt_duration !== 10'd0) begin
      bad++; $display("FAIL reset_rpt_data got=%0d/%0d exp=0/0", rpt_slot, rpt_duration); end
    total++; if (stay_alarm !== 4'b0) begin bad++; $display("FAIL reset_stay_alarm got=%b exp=0000", stay_alarm); end
    reset = 1'b1; entry_req = '0; exit_req = '0;
  endtask

  task automatic test_entry_exit();
    timer_count = 10'd100; entry_req = 4'b0010;
    tick();
    total++; if (entry_ack !== 4'b0010) begin bad++; $display("FAIL entry_ack got=%b exp=0010", entry_ack); end
    total++; if (occupied !== 4'b0010) begin bad++; $display("FAIL entry_occupied got=%b exp=0010", occupied); end
    entry_req = '0; timer_count = 10'd350; exit_req = 4'b0010; rpt_ready = 1'b1;
    tick();
    total++; if (exit_ack !== 4'b0010) begin bad++; $display("FAIL exit_ack got=%b exp=0010", exit_ack); end
    total++; if (rpt_valid !== 1'b1 || rpt_slot !== 2'd1) begin
      bad++; $display("FAIL exit_report got=v%b s%0d exp=v1 s1", rpt_valid, rpt_slot); end
    total++; if (rpt_duration !== 10'd250) begin bad++; $display("FAIL exit_duration got=%0d exp=250", rpt_duration); end
    total++; if (occupied !== 4'b0000) begin bad++; $display("FAIL exit_occupied got=%b exp=0000", occupied); end
    exit_req = '0;
    tick();
    total++; if (rpt_valid !== 1'b0 || exit_ack !== 4'b0) begin
      bad++; $display("FAIL exit_single_valid got=v%b ack%b exp=v0 ack0000", rpt_valid, exit_ack); end
  endtask

  task automatic test_wrap();
    timer_count = 10'd1000; entry_req = 4'b0001;
    tick();
    entry_req = '0; timer_count = 10'd40; exit_req = 4'b0001; rpt_ready = 1'b1;
    tick();
    total++; if (rpt_valid !== 1'b1 || rpt_slot !== 2'd0 || rpt_duration !== 10'd64) begin
      bad++; $display("FAIL wrap_duration got=v%b s%0d d%0d exp=v1 s0 d64", rpt_valid, rpt_slot, rpt_duration); end
    exit_req = '0;
    tick();
  endtask

  task automatic test_rr_entries();
    apply_reset();
    entry_req = 4'b1111;
    for (int k = 0; k < N; k++) begin
      logic [N-1:0] exp_ack;
      exp_ack = 4'b0001 << k;
      timer_count = 10'(200 + k);
      tick();
      total++; if (entry_ack !== exp_ack) begin bad++; $display("FAIL rr_entry_ack step=%0d got=%b exp=%b", k, entry_ack, exp_ack); end
    end
    tick();
    total++; if (entry_ack !== 4'b0 || occupied !== 4'b1111) begin
      bad++; $display("FAIL rr_entry_done got=ack%b occ%b exp=ack0000 occ1111", entry_ack, occupied); end
    entry_req = '0;
  endtask

  task automatic test_back_to_back_exits();
    timer_count = 10'd500; exit_req = 4'b0101; rpt_ready = 1'b0;
    tick();
    total++; if (exit_ack !== 4'b0001 || rpt_slot !== 2'd0 || rpt_duration !== 10'd300) begin
      bad++; $display("FAIL b2b_first got=ack%b s%0d d%0d exp=ack0001 s0 d300", exit_ack, rpt_slot, rpt_duration); end
    for (int c = 0; c < 4; c++) begin
      tick();
      total++; if (rpt_valid !== 1'b1 || rpt_slot !== 2'd0 || rpt_duration !== 10'd300 || exit_ack !== 4'b0) begin
        bad++; $display("FAIL b2b_hold cyc=%0d got=v%b s%0d d%0d ack%b exp=v1 s0 d300 ack0000",
                        c, rpt_valid, rpt_slot, rpt_duration, exit_ack); end
    end
    rpt_ready = 1'b1;
    tick();
    total++; if (rpt_valid !== 1'b0 || exit_ack !== 4'b0) begin
      bad++; $display("FAIL b2b_accept got=v%b ack%b exp=v0 ack0000", rpt_valid, exit_ack); end
    tick();
    total++; if (exit_ack !== 4'b0100 || rpt_valid !== 1'b1 || rpt_slot !== 2'd2 || rpt_duration !== 10'd298) begin
      bad++; $display("FAIL b2b_second got=ack%b v%b s%0d d%0d exp=ack0100 v1 s2 d298",
                      exit_ack, rpt_valid, rpt_slot, rpt_duration); end
    exit_req = '0;
    tick();
    total++; if (rpt_valid !== 1'b0 || occupied !== 4'b1010) begin
      bad++; $display("FAIL b2b_end got=v%b occ%b exp=v0 occ1010", rpt_valid, occupied); end
  endtask

  task automatic test_reset_mid_report();
    exit_req = 4'b0010; rpt_ready = 1'b0;
    tick();
    total++; if (rpt_valid !== 1'b1) begin bad++; $display("FAIL midrst_setup got=v%b exp=v1", rpt_valid); end
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    total++; if (rpt_valid !== 1'b0 || occupied !== 4'b0 || exit_ack !== 4'b0) begin
      bad++; $display("FAIL midrst_async got=v%b occ%b ack%b exp=v0 occ0000 ack0000", rpt_valid, occupied, exit_ack); end
    tick();
    reset = 1'b1; exit_req = '0;
  endtask

  task automatic test_stay_alarm();
    logic [N-1:0] exp_hi;
`ifdef STAY_ALARM_EN
    exp_hi = 4'b1000;
`else
    exp_hi = 4'b0000;
`endif
    timer_count = 10'd0; entry_req = 4'b1000;
    tick();
    entry_req = '0; timer_count = 10'd899;
    tick();
    total++; if (stay_alarm !== 4'b0) begin bad++; $display("FAIL alarm_below got=%b exp=0000", stay_alarm); end
    timer_count = 10'd900;
    tick();
    total++; if (stay_alarm !== exp_hi) begin bad++; $display("FAIL alarm_at_limit got=%b exp=%b", stay_alarm, exp_hi); end
    timer_count = 10'd950;
    tick();
    total++; if (stay_alarm !== exp_hi) begin bad++; $display("FAIL alarm_over got=%b exp=%b", stay_alarm, exp_hi); end
    timer_count = 10'd955; exit_req = 4'b1000; rpt_ready = 1'b1;
    tick();
    total++; if (stay_alarm !== 4'b0 || rpt_duration !== 10'd955) begin
      bad++; $display("FAIL alarm_clear got=%b d%0d exp=0000 d955", stay_alarm, rpt_duration); end
    exit_req = '0;
    tick();
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 500; c++) begin
      timer_count = timer_count + 10'($urandom_range(0, 40));
      entry_req   = 4'($urandom) & 4'($urandom);
      exit_req    = 4'($urandom);
      rpt_ready   = ($urandom_range(0, 3) != 0);
      tick();
      total++; if (entry_ack !== m_eack) begin bad++; $display("FAIL rand_entry_ack cyc=%0d got=%b exp=%b", c, entry_ack, m_eack); end
      total++; if (exit_ack !== m_xack) begin bad++; $display("FAIL rand_exit_ack cyc=%0d got=%b exp=%b", c, exit_ack, m_xack); end
      total++; if (occupied !== m_occ) begin bad++; $display("FAIL rand_occupied cyc=%0d got=%b exp=%b", c, occupied, m_occ); end
      total++; if (rpt_valid !== m_busy) begin bad++; $display("FAIL rand_rpt_valid cyc=%0d got=%b exp=%b", c, rpt_valid, m_busy); end
      total++; if (stay_alarm !== m_alarm) begin bad++; $display("FAIL rand_stay_alarm cyc=%0d got=%b exp=%b", c, stay_alarm, m_alarm); end
      if (m_busy) begin
        total++; if (rpt_slot !== 2'(m_rslot) || rpt_duration !== 10'(m_rdur)) begin
          bad++; $display("FAIL rand_report cyc=%0d got=s%0d d%0d exp=s%0d d%0d", c, rpt_slot, rpt_duration, m_rslot, m_rdur); end
      end
    end
    entry_req = '0; exit_req = '0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_entry_exit();
    test_wrap();
    test_rr_entries();
    test_back_to_back_exits();
    test_reset_mid_report();
    test_stay_alarm();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
